// File: rtl/controller_pkg.sv
// Shared constants and state encoding for the controller subsystem
// (clock divider, frequency meter).
package controller_pkg;

    localparam int CLK_Freq_50M = 50_000_000;
    localparam int GATE_1S      = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LATCH   = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle
// rising-edge pulse; also usable for push-button inputs.
module sync_edge_det (
    input  logic clk,
    input  logic n_clr,
    input  logic sig,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 holds the previous synchronized level
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts SigIn rising edges over GATE_CYCLES
// reference cycles and publishes the count with a one-cycle Valid strobe.
module freq_meter
    import controller_pkg::*;
#(
    parameter int CLK_Freq    = CLK_Freq_50M,
    parameter int GATE_CYCLES = GATE_1S,
    parameter int N           = 26
) (
    input  logic         CLK_50M,
    input  logic         nCLR,
    input  logic         Enable,
    input  logic         SigIn,
    output logic [N-1:0] FreqOut,
    output logic         Valid,
    output logic         Overflow,
    output logic         Busy
);

    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [N-1:0]    CNT_MAX   = '1;

    if (GATE_CYCLES < 2 || CLK_Freq < 2) begin : g_bad_params
        $error("freq_meter: GATE_CYCLES and CLK_Freq must both be at least 2");
    end

    meter_state_t  state;
    logic [GW-1:0] gate_cnt;
    logic [N-1:0]  edge_cnt;
    logic          sat;
    logic          sig_rise;
    logic [N-1:0]  cnt_next;
    logic          sat_next;

    sync_edge_det u_sync (
        .clk   (CLK_50M),
        .n_clr (nCLR),
        .sig   (SigIn),
        .pulse (sig_rise)
    );

    // Saturating edge count; sat marks an edge that could not be represented
    always_comb begin
        cnt_next = edge_cnt;
        sat_next = sat;
        if (sig_rise) begin
            if (edge_cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + N'(1);
            end
        end
    end

    // Outputs load on the edge that closes the window, so the final gate
    // cycle's edge goes straight into FreqOut and LATCH is the dead cycle.
    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            FreqOut  <= '0;
            Valid    <= 1'b0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    Busy     <= Enable;
                    if (Enable) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!Enable) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        state    <= LATCH;
                        Busy     <= 1'b0;
                        Valid    <= 1'b1;
                        FreqOut  <= cnt_next;
                        Overflow <= sat_next;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= cnt_next;
                        sat      <= sat_next;
                    end
                end
                LATCH: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    Busy     <= Enable;
                    state    <= Enable ? MEASURE : IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency meter, the measuring counterpart of the team's clock divider. It counts rising edges of an asynchronous input `SigIn` over a fixed gate window timed by `CLK_50M`, then publishes the count in Hz with a one-cycle valid strobe. It sits in the controller subsystem to check divided clocks (for example a 1 Hz output) and external pulse sources.

## Interface
Parameters:
- `CLK_Freq`, 50000000: reference clock frequency in Hz.
- `GATE_CYCLES`, 50000000: gate window length in `CLK_50M` cycles. The default is 1 s, so the count equals Hz. Range 2..2^26-1.
- `N`, 26: width of the edge counter and of `FreqOut`.

Ports:
- `CLK_50M`, in, 1: reference clock.
- `nCLR`, in, 1: reset, asynchronous, active-low.
- `Enable`, in, 1: synchronous run request; level-sensitive.
- `SigIn`, in, 1: measured signal, asynchronous to `CLK_50M`.
- `FreqOut`, out, N: last completed measurement (rising edges per gate).
- `Valid`, out, 1: one-cycle strobe when `FreqOut` updates.
- `Overflow`, out, 1: the last completed measurement saturated.
- `Busy`, out, 1: high while a gate window is open.

## Operation
- Reset values: all outputs 0, state IDLE, gate and edge counters 0, synchronizer flops 0.
- Input path: 2-FF synchronizer (s1, s2) plus a delay flop s3. `edge` = s2 & ~s3.
- States:
  - **IDLE**: counters are held at 0 and `Busy` is 0. If `Enable` is 1, go to MEASURE next cycle.
  - **MEASURE**: `Busy` is 1.
    - The gate counter increments every cycle.
    - The edge counter increments on `edge`, saturating at 2^N-1. If saturation is hit, a sticky internal `sat` flag is set.
    - When the gate counter equals GATE_CYCLES-1, go to LATCH. An edge arriving in that final cycle is counted.
    - If `Enable` is 0 in any MEASURE cycle, abort to IDLE: counters are cleared, `FreqOut`/`Overflow` are unchanged, and no `Valid` is produced.
  - **LATCH**, 1 cycle:
    - `FreqOut` <= edge count, `Overflow` <= `sat`, `Valid` = 1.
    - Counters and `sat` are cleared.
    - Next state is MEASURE if `Enable` is 1, else IDLE.
- Edges arriving in the LATCH cycle are dropped. Each window is therefore GATE_CYCLES counted cycles followed by 1 dead cycle.
- Measurable range is SigIn frequency < CLK_Freq/2. Each high and each low phase must last at least 2 clock cycles for exact counts.
- Gate counter width is $clog2(GATE_CYCLES).
- Arithmetic is unsigned and has no wrap. Saturation is the only overflow behaviour.

## Timing
- `SigIn` rise to `edge` asserted: 2–3 cycles, depending on metastability resolution.
- `Enable` rise (sampled) to the first MEASURE cycle: 1 cycle.
- Gate length: exactly GATE_CYCLES cycles. Measurement period with `Enable` held high: GATE_CYCLES+1 cycles between `Valid` strobes.
- Last MEASURE cycle to `Valid`: `Valid` is registered and high during the cycle after the LATCH decision. `FreqOut` is stable from that same edge.
- Asynchronous `nCLR` mid-window returns everything to reset values immediately. The first measurement after release needs a fresh `Enable` sample.
- `Busy` falls in the LATCH cycle and rises again the following cycle when running continuously.

## Structure
- Shared package `controller_pkg`:
  - constants `CLK_Freq_50M` and `GATE_1S`
  - state typedef/encoding {IDLE, MEASURE, LATCH}
- Sub-module `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse, reusable for button inputs.
- The FSM, gate counter, edge counter and output registers live in `freq_meter`.

## Test plan
All scenarios use GATE_CYCLES=1000 and N=10 for simulation speed.
- **Basic count:** reset, `Enable`=1, `SigIn` square wave with period 10 cycles → `Valid` every 1001 cycles, `FreqOut`=100 (±1 by phase), `Overflow`=0.
- **Zero input:** `SigIn` constant 0, then constant 1 → `FreqOut`=0 each window, `Valid` still strobes.
- **Saturation:** N=6, `SigIn` period 4 cycles (250 edges) → `FreqOut`=63, `Overflow`=1; the next window at period 40 gives `FreqOut`=25, `Overflow`=0.
- **Abort:** `Enable` dropped at gate cycle 500 → no `Valid`, `Busy`=0 next cycle, `FreqOut` keeps its previous value; re-enabling gives a full fresh window.
- **Reset mid-operation:** `nCLR` pulsed low at gate cycle 700 → `FreqOut`=0, `Valid`=0, `Overflow`=0, `Busy`=0 asynchronously; a measurement restarts after release.
- **Boundary edge:** a single `SigIn` rise timed so `edge` lands on gate cycle 999 → counted (`FreqOut`=1). A rise landing on the LATCH cycle → dropped from both windows.
